// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: key codes, scanner states
// and the row/column to key-code map.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hF;
    localparam logic [3:0] KEY_BKSP  = 4'hE;
    localparam logic [3:0] KEY_CLR   = 4'hC;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } scan_state_t;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scan, row synchroniser and press/release debounce for a 4x4 keypad.
// Emits a one-cycle press pulse with the decoded key code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W   = 15,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       press,
    output logic [3:0] press_code
);

    localparam int DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);

    logic [3:0]            row_meta_reg;
    logic [3:0]            rs_reg;
    logic [SCAN_DIV_W-1:0] scan_cnt_reg;
    logic [3:0]            col_reg;
    logic [DB_W-1:0]       db_cnt_reg;
    scan_state_t           state_reg;
    logic [1:0]            cap_row_reg;
    logic [1:0]            cap_col_reg;
    logic                  armed_reg;
    logic [1:0]            idle_cols_reg;
    logic                  press_reg;
    logic [3:0]            press_code_reg;

    logic [1:0] low_row;
    logic [1:0] col_idx;
    logic [3:0] col_next;

    always_comb begin
        low_row = 2'd3;
        if (!rs_reg[0])      low_row = 2'd0;
        else if (!rs_reg[1]) low_row = 2'd1;
        else if (!rs_reg[2]) low_row = 2'd2;
        case (col_reg)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
        col_next = {col_reg[2:0], col_reg[3]};
    end

    // Until the pad has been seen idle (four empty columns or a full release),
    // a detected key is tracked silently so a key held through reset is never reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_reg   <= 4'hF;
            rs_reg         <= 4'hF;
            scan_cnt_reg   <= '0;
            col_reg        <= 4'b1110;
            db_cnt_reg     <= '0;
            state_reg      <= SCAN;
            cap_row_reg    <= 2'd0;
            cap_col_reg    <= 2'd0;
            armed_reg      <= 1'b0;
            idle_cols_reg  <= 2'd0;
            press_reg      <= 1'b0;
            press_code_reg <= 4'h0;
        end else begin
            row_meta_reg <= key_row;
            rs_reg       <= row_meta_reg;
            press_reg    <= 1'b0;
            case (state_reg)
                SCAN: begin
                    scan_cnt_reg <= scan_cnt_reg + 1'b1;
                    if (&scan_cnt_reg) begin
                        if (rs_reg != 4'hF) begin
                            cap_row_reg <= low_row;
                            cap_col_reg <= col_idx;
                            db_cnt_reg  <= '0;
                            state_reg   <= armed_reg ? PRESS_DB : HELD;
                        end else begin
                            col_reg <= col_next;
                            if (!armed_reg) begin
                                idle_cols_reg <= idle_cols_reg + 1'b1;
                                if (idle_cols_reg == 2'd3) armed_reg <= 1'b1;
                            end
                        end
                    end
                end
                PRESS_DB: begin
                    if (rs_reg[cap_row_reg]) begin
                        state_reg    <= SCAN;
                        col_reg      <= col_next;
                        scan_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg      <= HELD;
                        press_reg      <= 1'b1;
                        press_code_reg <= key_lookup(cap_row_reg, cap_col_reg);
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
                HELD: begin
                    if (rs_reg == 4'hF) begin
                        db_cnt_reg <= '0;
                        state_reg  <= REL_DB;
                    end
                end
                REL_DB: begin
                    if (rs_reg != 4'hF) begin
                        state_reg <= HELD;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg    <= SCAN;
                        armed_reg    <= 1'b1;
                        col_reg      <= col_next;
                        scan_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= SCAN;
            endcase
        end
    end

    assign key_col    = col_reg;
    assign press      = press_reg;
    assign press_code = press_code_reg;

endmodule

// File: rtl/keypad_entry.sv
// Keypad numeric entry: builds a decimal number from keystrokes into a
// 28-bit binary word and commits it on enter.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W   = 15,
    parameter int DEBOUNCE_CNT = 500000,
    parameter int MAX_DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic [27:0] entry,
    output logic [3:0]  entry_digits,
    output logic [27:0] value,
    output logic        value_valid,
    output logic [3:0]  key_code,
    output logic        key_strobe
);

    logic       press;
    logic [3:0] press_code;

    logic [27:0] entry_reg;
    logic [3:0]  digits_reg;
    logic [27:0] value_reg;
    logic        value_valid_reg;
    logic [3:0]  key_code_reg;
    logic        key_strobe_reg;

    keypad_scanner #(
        .SCAN_DIV_W   (SCAN_DIV_W),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_scanner (
        .clk        (clk),
        .rst        (rst),
        .key_row    (key_row),
        .key_col    (key_col),
        .press      (press),
        .press_code (press_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_reg       <= '0;
            digits_reg      <= '0;
            value_reg       <= '0;
            value_valid_reg <= 1'b0;
            key_code_reg    <= 4'h0;
            key_strobe_reg  <= 1'b0;
        end else begin
            key_strobe_reg  <= 1'b0;
            value_valid_reg <= 1'b0;
            if (press) begin
                key_strobe_reg <= 1'b1;
                key_code_reg   <= press_code;
                if (press_code <= 4'd9) begin
                    // Excess digits are dropped rather than wrapping the word.
                    if (digits_reg < 4'(MAX_DIGITS)) begin
                        entry_reg  <= entry_reg * 28'd10 + 28'(press_code);
                        digits_reg <= digits_reg + 1'b1;
                    end
                end else begin
                    case (press_code)
                        KEY_ENTER: begin
                            value_reg       <= entry_reg;
                            value_valid_reg <= 1'b1;
                            entry_reg       <= '0;
                            digits_reg      <= '0;
                        end
                        KEY_BKSP: begin
                            entry_reg <= entry_reg / 28'd10;
                            if (digits_reg != 4'd0) digits_reg <= digits_reg - 1'b1;
                        end
                        KEY_CLR: begin
                            entry_reg  <= '0;
                            digits_reg <= '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign entry        = entry_reg;
    assign entry_digits = digits_reg;
    assign value        = value_reg;
    assign value_valid  = value_valid_reg;
    assign key_code     = key_code_reg;
    assign key_strobe   = key_strobe_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model drives rows from the active column and a
// behavioural calculator model predicts entry/value after every accepted key.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_q = 1'b1;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [27:0] entry;
    logic [3:0]  entry_digits;
    logic [27:0] value;
    logic        value_valid;
    logic [3:0]  key_code;
    logic        key_strobe;

    keypad_entry #(
        .SCAN_DIV_W   (2),
        .DEBOUNCE_CNT (4),
        .MAX_DIGITS   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_row      (key_row),
        .key_col      (key_col),
        .entry        (entry),
        .entry_digits (entry_digits),
        .value        (value),
        .value_valid  (value_valid),
        .key_code     (key_code),
        .key_strobe   (key_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    // Physical keypad: pressed key pulls its row low only while its column is driven.
    int pressed = 0;
    int pr = 0;
    int pc = 0;
    always_comb begin
        key_row = 4'hF;
        if (pressed != 0 && key_col[pc] == 1'b0) key_row[pr] = 1'b0;
    end

    int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int m_entry = 0;
    int m_digits = 0;
    int m_value = 0;
    bit strobe_seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_key(input int k);
        if (k <= 9) begin
            if (m_digits < 8) begin
                m_entry = m_entry * 10 + k;
                m_digits++;
            end
        end else if (k == 15) begin
            m_value = m_entry;
            m_entry = 0;
            m_digits = 0;
        end else if (k == 14) begin
            m_entry = m_entry / 10;
            if (m_digits > 0) m_digits--;
        end else if (k == 12) begin
            m_entry = 0;
            m_digits = 0;
        end
    endtask

    // Advance n cycles, comparing every output against the model at each falling edge.
    task automatic tick(input int n);
        int k;
        bit exp_valid;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst_q) begin
                m_entry = 0;
                m_digits = 0;
                m_value = 0;
                chk("rst_strobe", key_strobe, 0);
                chk("rst_valid", value_valid, 0);
                chk("rst_entry", entry, 0);
                chk("rst_value", value, 0);
                chk("rst_code", key_code, 0);
                chk("rst_col", key_col, 4'b1110);
            end else begin
                exp_valid = 0;
                if (key_strobe) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got code %0d expected no strobe at %0t", key_code, $time);
                    end else begin
                        k = exp_q.pop_front();
                        chk("key_code", key_code, k);
                        apply_key(k);
                        exp_valid = (k == 15);
                        strobe_seen = 1;
                        $display("key %h -> entry %0d digits %0d value %0d", key_code, entry, entry_digits, value);
                    end
                end
                chk("entry", entry, m_entry);
                chk("entry_digits", entry_digits, m_digits);
                chk("value", value, m_value);
                chk("value_valid", value_valid, exp_valid);
                chk("one_col_low", $countones(~key_col), 1);
            end
        end
    endtask

    task automatic set_key(input int code);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keymap[r][c] == code) begin
                    pr = r;
                    pc = c;
                end
    endtask

    task automatic press_key(input int code, input int hold);
        int waited = 0;
        set_key(code);
        exp_q.push_back(code);
        strobe_seen = 0;
        pressed = 1;
        while (!strobe_seen && waited < 60) begin
            tick(1);
            waited++;
        end
        chk("strobe_arrived", strobe_seen, 1);
        if (!strobe_seen) exp_q.delete();
        if (hold > waited) tick(hold - waited);
        pressed = 0;
        tick(25);
    endtask

    task automatic bounce(input int code);
        set_key(code);
        pressed = 1; tick(2);
        pressed = 0; tick(1);
        pressed = 1; tick(2);
        pressed = 0; tick(25);
    endtask

    initial begin
        logic [3:0] col_exp;
        int code;

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            col_exp = 4'b1110;
            for (int s = 0; s < k / 4; s++) col_exp = {col_exp[2:0], col_exp[3]};
            chk("col_rotation", key_col, col_exp);
            tick(1);
        end
        tick(10);

        press_key(1, 30); chk("entry_1", entry, 1);
        press_key(2, 30); chk("entry_12", entry, 12);
        press_key(3, 30); chk("entry_123", entry, 123);
        press_key(15, 30);
        chk("commit_value", value, 123);
        chk("commit_entry", entry, 0);
        chk("commit_digits", entry_digits, 0);

        bounce(5);
        chk("bounce_entry", entry, 0);

        for (int i = 0; i < 8; i++) press_key(9, 30);
        chk("nines_entry", entry, 99999999);
        chk("nines_digits", entry_digits, 8);
        press_key(9, 30);
        chk("ninth_code", key_code, 9);
        chk("ninth_entry", entry, 99999999);

        press_key(12, 30);
        press_key(1, 30); press_key(2, 30); press_key(3, 30);
        press_key(14, 30);
        chk("bksp_entry", entry, 12);
        chk("bksp_digits", entry_digits, 2);
        press_key(12, 30);
        chk("clr_entry", entry, 0);
        press_key(14, 30);
        chk("bksp_empty_entry", entry, 0);
        chk("bksp_empty_digits", entry_digits, 0);

        press_key(5, 200);
        set_key(5);
        exp_q.push_back(5);
        strobe_seen = 0;
        pressed = 1;
        tick(60);
        chk("held5_strobe", strobe_seen, 1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(80);
        pressed = 0;
        tick(25);
        press_key(5, 30);
        chk("after_reset_entry", entry, 5);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                bounce($urandom_range(0, 15));
            end else begin
                code = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
                press_key(code, $urandom_range(30, 60));
            end
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
